// File: rtl/mpt_pkg.sv
// rtl/mpt_pkg.sv - shared defaults and record types for the MPT forwarding cache
package mpt_pkg;

   localparam int MPT_TXN_W    = 32;
   localparam int MPT_TAG_W    = 20;
   localparam int MPT_PPN_W    = 22;
   localparam int MPT_FB_DEPTH = 8;
   localparam int MPT_CNT_W    = 16;

   // One forwarding-buffer slot at the default geometry.
   typedef struct packed {
      logic                 valid;
      logic [MPT_TAG_W-1:0] tag;
      logic [MPT_PPN_W-1:0] ppn;
   } fb_entry_t;

   // Result bundle presented toward the Memory Stage at the default geometry.
   typedef struct packed {
      logic [MPT_TXN_W-1:0] data;
      logic                 hit;
      logic [MPT_PPN_W-1:0] ppn;
   } fb_result_t;

endpackage

// File: rtl/forwarding_buffer_cam.sv
// rtl/forwarding_buffer_cam.sv - fully associative tag/PPN store with first-free and round-robin refill
module forwarding_buffer_cam
   import mpt_pkg::*;
#(
   parameter int TAG_WIDTH = MPT_TAG_W,
   parameter int PPN_WIDTH = MPT_PPN_W,
   parameter int DEPTH     = MPT_FB_DEPTH
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic [TAG_WIDTH-1:0] lkp_tag_i,
   output logic                 lkp_hit_o,
   output logic [PPN_WIDTH-1:0] lkp_ppn_o,
   input  logic                 upd_valid_i,
   input  logic [TAG_WIDTH-1:0] upd_tag_i,
   input  logic [PPN_WIDTH-1:0] upd_ppn_i
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [DEPTH-1:0]     valid_q;
   logic [TAG_WIDTH-1:0] tag_q [DEPTH];
   logic [PPN_WIDTH-1:0] ppn_q [DEPTH];
   logic [IDX_W-1:0]     ptr_q, ptr_d;

   logic [DEPTH-1:0]     lkp_match, upd_match;
   logic [IDX_W-1:0]     lkp_idx, upd_idx, free_idx, wr_idx;
   logic                 free_found, wr_en;

   // Compare both the lookup tag and the refill tag against every valid slot.
   always_comb begin
      lkp_match = '0;
      upd_match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         lkp_match[i] = valid_q[i] && (tag_q[i] == lkp_tag_i);
         upd_match[i] = valid_q[i] && (tag_q[i] == upd_tag_i);
      end
   end

   // Tags are unique, so OR-ing indices of set bits encodes the one-hot match.
   always_comb begin
      lkp_idx = '0;
      upd_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (lkp_match[i]) lkp_idx = lkp_idx | IDX_W'(i);
         if (upd_match[i]) upd_idx = upd_idx | IDX_W'(i);
      end
   end

   // Lowest-index invalid slot; scanning downward leaves the smallest index last.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   assign lkp_hit_o = |lkp_match;
   assign lkp_ppn_o = lkp_hit_o ? ppn_q[lkp_idx] : '0;

   // Refill target: existing tag first, then a free slot, else evict at the pointer.
   always_comb begin
      wr_en  = upd_valid_i && !flush_i;
      wr_idx = ptr_q;
      ptr_d  = ptr_q;
      if (|upd_match) begin
         wr_idx = upd_idx;
      end else if (free_found) begin
         wr_idx = free_idx;
      end else if (wr_en) begin
         ptr_d = (ptr_q == IDX_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
      end
   end

   // Valid bits and replacement pointer; flush empties the table.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         valid_q <= '0;
         ptr_q   <= '0;
      end else begin
         ptr_q <= ptr_d;
         if (wr_en) valid_q[wr_idx] <= 1'b1;
      end
   end

   // Slot payload; meaningless while the valid bit is clear, so left unreset.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         tag_q[wr_idx] <= upd_tag_i;
         ppn_q[wr_idx] <= upd_ppn_i;
      end
   end

endmodule

// File: rtl/mpt_forwarding_cache.sv
// rtl/mpt_forwarding_cache.sv - PPN forwarding cache between MPTE parsing and the Memory Stage
module mpt_forwarding_cache
   import mpt_pkg::*;
#(
   parameter int TRANSACTION_DATA_WIDTH  = MPT_TXN_W,
   parameter int TAG_WIDTH               = MPT_TAG_W,
   parameter int PPN_WIDTH               = MPT_PPN_W,
   parameter int FORWARDING_BUFFER_DEPTH = MPT_FB_DEPTH,
   parameter int CNT_WIDTH               = MPT_CNT_W
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              flush_i,
   input  logic                              lkp_valid_i,
   output logic                              lkp_ready_o,
   input  logic [TAG_WIDTH-1:0]              lkp_tag_i,
   input  logic [TRANSACTION_DATA_WIDTH-1:0] lkp_data_i,
   input  logic                              upd_valid_i,
   output logic                              upd_ready_o,
   input  logic [TAG_WIDTH-1:0]              upd_tag_i,
   input  logic [PPN_WIDTH-1:0]              upd_ppn_i,
   output logic                              out_valid_o,
   input  logic                              out_ready_i,
   output logic [TRANSACTION_DATA_WIDTH-1:0] out_data_o,
   output logic                              out_hit_o,
   output logic [PPN_WIDTH-1:0]              out_ppn_o,
   output logic [CNT_WIDTH-1:0]              hit_cnt_o,
   output logic [CNT_WIDTH-1:0]              miss_cnt_o
);

   logic                              out_valid_q, out_valid_d;
   logic [TRANSACTION_DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                              out_hit_q, out_hit_d;
   logic [PPN_WIDTH-1:0]              out_ppn_q, out_ppn_d;
   logic [CNT_WIDTH-1:0]              hit_cnt_q, hit_cnt_d;
   logic [CNT_WIDTH-1:0]              miss_cnt_q, miss_cnt_d;

   logic                 lkp_fire;
   logic                 tbl_hit, byp_hit, res_hit;
   logic [PPN_WIDTH-1:0] tbl_ppn, res_ppn;

   assign upd_ready_o = 1'b1;
   assign lkp_ready_o = !flush_i && (!out_valid_q || out_ready_i);
   assign lkp_fire    = lkp_valid_i && lkp_ready_o;

   forwarding_buffer_cam #(
      .TAG_WIDTH (TAG_WIDTH),
      .PPN_WIDTH (PPN_WIDTH),
      .DEPTH     (FORWARDING_BUFFER_DEPTH)
   ) u_cam (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .lkp_tag_i   (lkp_tag_i),
      .lkp_hit_o   (tbl_hit),
      .lkp_ppn_o   (tbl_ppn),
      .upd_valid_i (upd_valid_i),
      .upd_tag_i   (upd_tag_i),
      .upd_ppn_i   (upd_ppn_i)
   );

   // Same-cycle refill of the looked-up tag wins over the pre-edge table contents.
   always_comb begin
      byp_hit = upd_valid_i && (upd_tag_i == lkp_tag_i);
      res_hit = byp_hit || tbl_hit;
      res_ppn = byp_hit ? upd_ppn_i : tbl_ppn;
   end

   // Output stage and statistics: load on accept, drain on ready, kill on flush.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_hit_d   = out_hit_q;
      out_ppn_d   = out_ppn_q;
      hit_cnt_d   = hit_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      if (flush_i) begin
         out_valid_d = 1'b0;
      end else if (lkp_fire) begin
         out_valid_d = 1'b1;
         out_data_d  = lkp_data_i;
         out_hit_d   = res_hit;
         out_ppn_d   = res_ppn;
         if (res_hit) begin
            if (hit_cnt_q != {CNT_WIDTH{1'b1}}) hit_cnt_d = hit_cnt_q + 1'b1;
         end else begin
            if (miss_cnt_q != {CNT_WIDTH{1'b1}}) miss_cnt_d = miss_cnt_q + 1'b1;
         end
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   // Output register and counters.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_hit_q   <= 1'b0;
         out_ppn_q   <= '0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_hit_q   <= out_hit_d;
         out_ppn_q   <= out_ppn_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_hit_o   = out_hit_q;
   assign out_ppn_o   = out_ppn_q;
   assign hit_cnt_o   = hit_cnt_q;
   assign miss_cnt_o  = miss_cnt_q;

endmodule

// File: tb/tb_mpt_forwarding_cache.sv
// tb/tb_mpt_forwarding_cache.sv - scoreboard bench for mpt_forwarding_cache
module tb_mpt_forwarding_cache;

   localparam int DW = 32;
   localparam int TW = 20;
   localparam int PW = 22;
   localparam int D  = 8;
   localparam int CW = 16;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst, flush;
   logic          lkp_valid, lkp_ready;
   logic [TW-1:0] lkp_tag;
   logic [DW-1:0] lkp_data;
   logic          upd_valid, upd_ready;
   logic [TW-1:0] upd_tag;
   logic [PW-1:0] upd_ppn;
   logic          out_valid, out_ready, out_hit;
   logic [DW-1:0] out_data;
   logic [PW-1:0] out_ppn;
   logic [CW-1:0] hit_cnt, miss_cnt;

   always #5 clk = ~clk;

   mpt_forwarding_cache #(
      .TRANSACTION_DATA_WIDTH  (DW),
      .TAG_WIDTH               (TW),
      .PPN_WIDTH               (PW),
      .FORWARDING_BUFFER_DEPTH (D),
      .CNT_WIDTH               (CW)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .lkp_valid_i (lkp_valid),
      .lkp_ready_o (lkp_ready),
      .lkp_tag_i   (lkp_tag),
      .lkp_data_i  (lkp_data),
      .upd_valid_i (upd_valid),
      .upd_ready_o (upd_ready),
      .upd_tag_i   (upd_tag),
      .upd_ppn_i   (upd_ppn),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .out_hit_o   (out_hit),
      .out_ppn_o   (out_ppn),
      .hit_cnt_o   (hit_cnt),
      .miss_cnt_o  (miss_cnt)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic          hit;
      logic [PW-1:0] ppn;
      int            hc;
      int            mc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference table: slots fill in order from 0 and are only ever emptied all at once.
   logic [TW-1:0] m_tag [D];
   logic [PW-1:0] m_ppn [D];
   int            m_used = 0;
   int            m_ptr  = 0;
   bit            m_ov   = 1'b0;
   int            m_hc   = 0;
   int            m_mc   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic int m_find(input logic [TW-1:0] t);
      for (int i = 0; i < m_used; i++)
         if (m_tag[i] == t) return i;
      return -1;
   endfunction

   task automatic m_refill(input logic [TW-1:0] t, input logic [PW-1:0] p);
      int k;
      k = m_find(t);
      if (k >= 0) begin
         m_ppn[k] = p;
      end else if (m_used < D) begin
         m_tag[m_used] = t;
         m_ppn[m_used] = p;
         m_used++;
      end else begin
         m_tag[m_ptr] = t;
         m_ppn[m_ptr] = p;
         m_ptr = (m_ptr + 1) % D;
      end
   endtask

   // One clock of stimulus; the model advances as the DUT will at the coming edge.
   task automatic step(input bit fl, input bit lv, input logic [TW-1:0] lt, input logic [DW-1:0] ld,
                       input bit uv, input logic [TW-1:0] ut, input logic [PW-1:0] up, input bit ordy);
      bit   er, acc;
      exp_t e;
      int   k;
      flush = fl; lkp_valid = lv; lkp_tag = lt; lkp_data = ld;
      upd_valid = uv; upd_tag = ut; upd_ppn = up; out_ready = ordy;
      er = !fl && (!m_ov || ordy);
      #1;
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
      chk("lkp_ready", {63'd0, lkp_ready}, {63'd0, er});
      acc = lv && er;
      if (acc) begin
         e.data = ld; e.hit = 1'b0; e.ppn = '0;
         if (uv && ut == lt) begin
            e.hit = 1'b1; e.ppn = up;
         end else begin
            k = m_find(lt);
            if (k >= 0) begin
               e.hit = 1'b1; e.ppn = m_ppn[k];
            end
         end
         if (e.hit) begin
            if (m_hc < CNT_MAX) m_hc++;
         end else begin
            if (m_mc < CNT_MAX) m_mc++;
         end
         e.hc = m_hc; e.mc = m_mc;
         sb.push_back(e);
      end
      if (fl) m_ov = 1'b0;
      else if (acc) m_ov = 1'b1;
      else if (ordy) m_ov = 1'b0;
      if (fl) begin
         m_used = 0; m_ptr = 0;
      end else if (uv) begin
         m_refill(ut, up);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input logic [TW-1:0] t, input bit ordy);
      step(1'b0, 1'b1, t, DW'($urandom), 1'b0, '0, '0, ordy);
   endtask

   task automatic refill(input logic [TW-1:0] t, input logic [PW-1:0] p);
      step(1'b0, 1'b0, '0, '0, 1'b1, t, p, 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; lkp_valid = 1'b0; upd_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_used = 0; m_ptr = 0; m_ov = 1'b0; m_hc = 0; m_mc = 0;
   endtask

   task automatic check_idle_outputs();
      chk("rst out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst out_data", {32'd0, out_data}, 64'd0);
      chk("rst out_hit", {63'd0, out_hit}, 64'd0);
      chk("rst out_ppn", {42'd0, out_ppn}, 64'd0);
      chk("rst hit_cnt", {48'd0, hit_cnt}, 64'd0);
      chk("rst miss_cnt", {48'd0, miss_cnt}, 64'd0);
      chk("rst upd_ready", {63'd0, upd_ready}, 64'd1);
   endtask

   // Monitor: the presented result must match the oldest outstanding expectation.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_output: data=%0h with no pending lookup", out_data);
            end else begin
               e = sb[0];
               n_cmp++;
               if (out_data !== e.data || out_hit !== e.hit || out_ppn !== e.ppn ||
                   int'(hit_cnt) != e.hc || int'(miss_cnt) != e.mc) begin
                  n_bad++;
                  $display("FAIL out_result: actual data=%0h hit=%b ppn=%0h hc=%0d mc=%0d required data=%0h hit=%b ppn=%0h hc=%0d mc=%0d",
                           out_data, out_hit, out_ppn, hit_cnt, miss_cnt, e.data, e.hit, e.ppn, e.hc, e.mc);
               end
               if (out_ready === 1'b1 || flush === 1'b1 || rst === 1'b1) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin : stimulus
      int guard;
      rst = 1'b1; flush = 1'b0; lkp_valid = 1'b0; lkp_tag = '0; lkp_data = '0;
      upd_valid = 1'b0; upd_tag = '0; upd_ppn = '0; out_ready = 1'b1;
      do_reset();
      check_idle_outputs();

      lookup(20'h12345, 1'b1);
      step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);

      step(1'b0, 1'b1, 20'h0000A, 32'hB0B0_0001, 1'b1, 20'h0000A, 22'h3FF0, 1'b1);
      lookup(20'h0000A, 1'b1);

      step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
      for (int i = 0; i < 9; i++) refill(TW'(32'h100 + i), PW'(32'h200 + i));
      for (int i = 0; i < 9; i++) lookup(TW'(32'h100 + i), 1'b1);

      refill(20'h105, 22'h1);
      lookup(20'h105, 1'b1);
      lookup(20'h101, 1'b1);

      lookup(20'h777, 1'b1);
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 20'h777, 32'hDEAD_0000, 1'b1, 20'h777, 22'h55, 1'b0);
      lookup(20'h777, 1'b1);

      step(1'b1, 1'b1, 20'h106, 32'hF1F1_F1F1, 1'b1, 20'h999, 22'h7, 1'b1);
      lookup(20'h106, 1'b1);
      lookup(20'h999, 1'b1);
      lookup(20'h103, 1'b1);

      for (int c = 0; c < 3000; c++) begin
         step(($urandom % 50) == 0, ($urandom % 4) != 0, TW'(32'h300 + $urandom % 12), DW'($urandom),
              ($urandom % 3) == 0, TW'(32'h300 + $urandom % 12), PW'($urandom), ($urandom % 4) != 0);
      end

      lookup(20'h300, 1'b0);
      do_reset();
      check_idle_outputs();
      chk("rst drops in-flight", 64'(sb.size()), 64'd0);
      lookup(20'h300, 1'b1);

      guard = 0;
      while (sb.size() != 0 && guard < 20) begin
         step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
         guard++;
      end
      chk("scoreboard drained", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
